// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the EX/MEM pipeline stage: ALU control codes,
// buffer occupancy encoding and the packed entry carried between stages.
package ex_mem_stage_pkg;

  localparam int EXM_DATA_W = 32;
  localparam int EXM_REG_AW = 5;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_ONE   = 2'b01,
    OCC_TWO   = 2'b10
  } occ_state_t;

  typedef struct packed {
    logic [EXM_DATA_W-1:0] result;
    logic [EXM_DATA_W-1:0] store_data;
    logic [EXM_REG_AW-1:0] rd;
    logic                  regwrite;
    logic                  memread;
    logic                  memwrite;
    logic                  memtoreg;
    logic                  zero;
    logic                  sign;
    logic                  ovf;
  } ex_mem_entry_t;

  // The ALU overflow flag is only meaningful for add and subtract; the
  // explicit select keeps an unknown flag on other opcodes from leaking out.
  function automatic logic qualify_ovf(input logic [2:0] ctl, input logic vout);
    logic q;
    if ((ctl == ALU_ADD) || (ctl == ALU_SUB)) begin
      q = vout;
    end else begin
      q = 1'b0;
    end
    return q;
  endfunction

endpackage

// File: rtl/ex_mem_stage_skid_buf2.sv
// Generic 2-entry valid/ready skid buffer with registered in_ready/out_valid
// and strict FIFO order; flush empties the buffer and outranks both handshakes.
module skid_buf2
  import ex_mem_stage_pkg::*;
#(
  parameter type entry_t = logic [7:0]
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   flush,
  input  logic   in_valid,
  output logic   in_ready,
  input  entry_t in_data,
  output logic   out_valid,
  input  logic   out_ready,
  output entry_t out_data
);

  occ_state_t state_r, state_s;
  entry_t     head_r, head_s;
  entry_t     skid_r, skid_s;
  logic       in_ready_r, in_ready_s;
  logic       out_valid_r, out_valid_s;
  logic       accept_s, deq_s;

  assign accept_s  = in_valid && in_ready_r;
  assign deq_s     = out_valid_r && out_ready;
  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = head_r;

  // Next occupancy and entry movement; handshakes decode from next state so both stay registered.
  always_comb begin
    state_s = state_r;
    head_s  = head_r;
    skid_s  = skid_r;
    if (flush) begin
      state_s = OCC_EMPTY;
    end else begin
      case (state_r)
        OCC_EMPTY: begin
          if (accept_s) begin
            head_s  = in_data;
            state_s = OCC_ONE;
          end else begin
            state_s = OCC_EMPTY;
          end
        end
        OCC_ONE: begin
          if (accept_s && deq_s) begin
            head_s  = in_data;
            state_s = OCC_ONE;
          end else if (accept_s) begin
            skid_s  = in_data;
            state_s = OCC_TWO;
          end else if (deq_s) begin
            state_s = OCC_EMPTY;
          end else begin
            state_s = OCC_ONE;
          end
        end
        OCC_TWO: begin
          if (deq_s) begin
            head_s  = skid_r;
            state_s = OCC_ONE;
          end else begin
            state_s = OCC_TWO;
          end
        end
        default: begin
          state_s = OCC_EMPTY;
        end
      endcase
    end

    case (state_s)
      OCC_EMPTY: begin
        out_valid_s = 1'b0;
        in_ready_s  = 1'b1;
      end
      OCC_ONE: begin
        out_valid_s = 1'b1;
        in_ready_s  = 1'b1;
      end
      OCC_TWO: begin
        out_valid_s = 1'b1;
        in_ready_s  = 1'b0;
      end
      default: begin
        out_valid_s = 1'b0;
        in_ready_s  = 1'b1;
      end
    endcase
  end

  // State, handshake and payload registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= OCC_EMPTY;
      head_r      <= '0;
      skid_r      <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      head_r      <= head_s;
      skid_r      <= skid_s;
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: qualifies ALU overflow by opcode, buffers entries
// in a 2-entry skid buffer and keeps a sticky overflow status (EX_MEM_STICKY_OVF_EN).
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu_out,
  input  logic              in_zout,
  input  logic              in_vout,
  input  logic              in_sout,
  input  logic [2:0]        in_alu_ctl,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_regwrite,
  input  logic              in_memread,
  input  logic              in_memwrite,
  input  logic              in_memtoreg,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_alu_out,
  output logic [DATA_W-1:0] out_store_data,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_regwrite,
  output logic              out_memread,
  output logic              out_memwrite,
  output logic              out_memtoreg,
  output logic              out_zero,
  output logic              out_sign,
  output logic              out_ovf,
  output logic              ovf_sticky,
  input  logic              ovf_clr
);

`ifdef EX_MEM_STICKY_OVF_EN
  localparam logic STICKY_EN = 1'b1;
`else
  localparam logic STICKY_EN = 1'b0;
`endif

  ex_mem_entry_t in_entry_s, out_entry_s;
  logic          ovf_q_s;
  logic          accept_s;
  logic          sticky_r;

  assign ovf_q_s  = qualify_ovf(in_alu_ctl, in_vout);
  assign accept_s = in_valid && in_ready;

  // Pack the incoming payload; only the overflow flag is altered on the way in.
  always_comb begin
    in_entry_s            = '0;
    in_entry_s.result     = in_alu_out;
    in_entry_s.store_data = in_store_data;
    in_entry_s.rd         = in_rd;
    in_entry_s.regwrite   = in_regwrite;
    in_entry_s.memread    = in_memread;
    in_entry_s.memwrite   = in_memwrite;
    in_entry_s.memtoreg   = in_memtoreg;
    in_entry_s.zero       = in_zout;
    in_entry_s.sign       = in_sout;
    in_entry_s.ovf        = ovf_q_s;
  end

  skid_buf2 #(
    .entry_t (ex_mem_entry_t)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_entry_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_entry_s)
  );

  assign out_alu_out    = out_entry_s.result;
  assign out_store_data = out_entry_s.store_data;
  assign out_rd         = out_entry_s.rd;
  assign out_regwrite   = out_entry_s.regwrite;
  assign out_memread    = out_entry_s.memread;
  assign out_memwrite   = out_entry_s.memwrite;
  assign out_memtoreg   = out_entry_s.memtoreg;
  assign out_zero       = out_entry_s.zero;
  assign out_sign       = out_entry_s.sign;
  assign out_ovf        = out_entry_s.ovf;

  // Sticky overflow: an accepted overflow (even one later flushed) beats a clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sticky_r <= 1'b0;
    end else if (STICKY_EN && accept_s && ovf_q_s) begin
      sticky_r <= 1'b1;
    end else if (STICKY_EN && ovf_clr) begin
      sticky_r <= 1'b0;
    end else begin
      sticky_r <= sticky_r;
    end
  end

  assign ovf_sticky = STICKY_EN ? sticky_r : 1'b0;

endmodule
